// File: rtl/pc_gen.sv
// Fetch PC generator: next-PC selection, EX-stage mispredict redirect and an optional
// direct-mapped BTB with 2-bit counters, compiled in when PC_GEN_BTB_EN is defined.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     BTB_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [2:0]      next_pc_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            redirect,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] PcInc = XLEN'(32'd4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;
    logic            actual_taken;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + PcInc;

    // Resolve the real control flow of the EX-stage instruction.
    always_comb begin
        actual_taken = 1'b0;
        target       = ex_pc + PcInc;
        case (next_pc_op)
            3'b001, 3'b010: begin
                actual_taken = 1'b1;
                target       = ex_pc + ex_imm;
            end
            3'b011: begin
                actual_taken = 1'b1;
                target       = {ex_alu_result[XLEN-1:1], 1'b0};
            end
            default: begin
                actual_taken = 1'b0;
                target       = ex_pc + PcInc;
            end
        endcase
    end

    assign redirect   = ex_valid & ((actual_taken != ex_pred_taken) |
                                    (actual_taken & ex_pred_taken & (target != ex_pred_target)));
    assign misaligned = redirect & target[1];

`ifdef PC_GEN_BTB_EN
    localparam int unsigned IdxW = $clog2(BTB_DEPTH);
    localparam int unsigned TagW = XLEN - IdxW - 2;

    logic            btb_valid_q [BTB_DEPTH];
    logic [TagW-1:0] btb_tag_q   [BTB_DEPTH];
    logic [XLEN-1:0] btb_tgt_q   [BTB_DEPTH];
    logic [1:0]      btb_cnt_q   [BTB_DEPTH];

    logic [IdxW-1:0] lk_idx, up_idx;
    logic [TagW-1:0] lk_tag, up_tag;
    logic            lk_hit, up_hit;
    logic [1:0]      up_cnt, inc_cnt, dec_cnt;

    assign lk_idx = pc_q[IdxW+1:2];
    assign lk_tag = pc_q[XLEN-1:IdxW+2];
    assign up_idx = ex_pc[IdxW+1:2];
    assign up_tag = ex_pc[XLEN-1:IdxW+2];

    assign lk_hit = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    assign up_cnt = btb_cnt_q[up_idx];

    assign inc_cnt = (up_cnt == 2'b11) ? 2'b11 : up_cnt + 2'd1;
    assign dec_cnt = (up_cnt == 2'b00) ? 2'b00 : up_cnt - 2'd1;

    // Lookup reads the registered contents, so a same-cycle update is seen only next cycle.
    assign pred_taken  = lk_hit & btb_cnt_q[lk_idx][1];
    assign pred_target = pred_taken ? btb_tgt_q[lk_idx] : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BTB_DEPTH); i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                btb_cnt_q[i]   <= 2'b00;
            end
        end else if (ex_valid && actual_taken) begin
            btb_valid_q[up_idx] <= 1'b1;
            btb_tag_q[up_idx]   <= up_tag;
            btb_tgt_q[up_idx]   <= target;
            btb_cnt_q[up_idx]   <= up_hit ? inc_cnt : 2'b10;
        end else if (ex_valid && ex_is_branch && up_hit) begin
            btb_cnt_q[up_idx]   <= dec_cnt;
        end
    end
`else
    logic unused_btb_in;
    assign unused_btb_in = ex_is_branch;

    assign pred_taken  = 1'b0;
    assign pred_target = pc_plus4;
`endif

    // pred_target already falls back to pc+4 when no prediction is made.
    always_comb begin
        pc_d = pred_target;
        if (redirect) begin
            pc_d = target;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected next PCs are queued at drive time and compared
// after the following clock edge; BTB expectations follow PC_GEN_BTB_EN.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [2:0]  next_pc_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect;
    logic        misaligned;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;

    // Reference BTB: 8 entries, index pc[4:2], tag pc[31:5].
    logic        m_valid [8];
    logic [26:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    logic [1:0]  m_cnt   [8];

    pc_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .next_pc_op    (next_pc_op),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_alu_result (ex_alu_result),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .redirect      (redirect),
        .misaligned    (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 2'b00;
        end
    endtask

    task automatic step(input logic st, input logic v, input logic br, input logic [2:0] op,
                        input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] alu,
                        input logic ept, input logic [31:0] eptgt, input logic [31:0] tgt,
                        input logic exp_redir, input logic exp_mis);
        logic        pt;
        logic [31:0] ptg;
        logic [31:0] nxt;
        logic        taken;
        logic        hit;
        logic [2:0]  ui;
        logic [2:0]  li;
        stall          = st;
        ex_valid       = v;
        ex_is_branch   = br;
        next_pc_op     = op;
        ex_pc          = epc;
        ex_imm         = imm;
        ex_alu_result  = alu;
        ex_pred_taken  = ept;
        ex_pred_target = eptgt;
        #1;
        li  = exp_pc[4:2];
        pt  = 1'b0;
`ifdef PC_GEN_BTB_EN
        pt  = m_valid[li] && (m_tag[li] == exp_pc[31:5]) && m_cnt[li][1];
`endif
        ptg = pt ? m_tgt[li] : exp_pc + 32'd4;
        check_eq("redirect", {31'b0, redirect}, {31'b0, exp_redir});
        check_eq("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
        check_eq("pred_taken", {31'b0, pred_taken}, {31'b0, pt});
        check_eq("pred_target", pred_target, ptg);
        check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
        nxt = exp_redir ? tgt : (st ? exp_pc : ptg);
        exp_q.push_back(nxt);
        taken = (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
        ui    = epc[4:2];
        hit   = m_valid[ui] && (m_tag[ui] == epc[31:5]);
        if (v && taken) begin
            m_cnt[ui]   = !hit ? 2'b10 : (m_cnt[ui] == 2'b11 ? 2'b11 : m_cnt[ui] + 2'd1);
            m_valid[ui] = 1'b1;
            m_tag[ui]   = epc[31:5];
            m_tgt[ui]   = tgt;
        end else if (v && br && hit) begin
            m_cnt[ui]   = (m_cnt[ui] == 2'b00) ? 2'b00 : m_cnt[ui] - 2'd1;
        end
        @(posedge clk);
        #1;
        exp_pc = exp_q.pop_front();
        check_eq("pc", pc, exp_pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jalr_to(input logic [31:0] epc, input logic [31:0] dst);
        step(0, 1, 0, 3'b011, epc, 0, dst, 0, 0, dst, 1, dst[1]);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc_plus4", pc_plus4, 32'h4);
        check_eq("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        check_eq("rst_pred_target", pred_target, 32'h4);
        #9 rst_n = 1'b1;
        #1;
        exp_pc = 32'h0;
        check_eq("rel_pc", pc, 32'h0);

        // Sequential fetch 4, 8, C, 10, then stall three cycles at 0x10.
        idle(4);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check_eq("after_stall", pc, 32'h14);

        // jal at 0x20 unpredicted, then revisit 0x20.
        step(0, 1, 0, 3'b010, 32'h20, 32'h40, 0, 0, 0, 32'h60, 1, 0);
        check_eq("jal_pc", pc, 32'h60);
        jalr_to(32'h44, 32'h20);
`ifdef PC_GEN_BTB_EN
        check_eq("jal_btb_hit", {31'b0, pred_taken}, 32'h1);
        check_eq("jal_btb_tgt", pred_target, 32'h60);
`endif
        idle(1);

        // jalr with odd bit1 target: bit0 cleared, bit1 flagged.
        step(0, 1, 0, 3'b011, 32'h48, 0, 32'h103, 0, 0, 32'h102, 1, 1);
        check_eq("jalr_pc", pc, 32'h102);
        idle(1);

        // Branch at 0x30: taken twice, then not-taken three times.
        step(0, 1, 1, 3'b001, 32'h30, 32'h10, 0, 0, 0, 32'h40, 1, 0);
        step(0, 1, 1, 3'b001, 32'h30, 32'h10, 0, 1, 32'h40, 32'h40, 0, 0);
        step(0, 1, 1, 3'b000, 32'h30, 32'h10, 0, 1, 32'h40, 32'h34, 1, 0);
        step(0, 1, 1, 3'b000, 32'h30, 32'h10, 0, 0, 0, 32'h34, 0, 0);
        step(0, 1, 1, 3'b000, 32'h30, 32'h10, 0, 0, 0, 32'h34, 0, 0);
        jalr_to(32'h58, 32'h30);
        check_eq("br_cnt_zero", {31'b0, pred_taken}, 32'h0);
        idle(1);

        // Redirect wins over stall.
        step(1, 1, 0, 3'b010, 32'h80, 32'h100, 0, 0, 0, 32'h180, 1, 0);
        check_eq("redir_stall", pc, 32'h180);

        // Predicted-taken but resolved sequential, and an undefined op.
        step(0, 1, 0, 3'b000, 32'h200, 0, 0, 1, 32'h300, 32'h204, 1, 0);
        step(0, 1, 0, 3'b111, 32'h8, 32'h40, 32'h40, 0, 0, 32'hc, 0, 0);

        // Address wrap.
        jalr_to(32'h8c, 32'hffff_fffc);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        idle(1);
        check_eq("wrap_pc", pc, 32'h0);
        idle(2);

        // Reset in the middle of an update cycle.
        ex_valid   = 1'b1;
        next_pc_op = 3'b010;
        ex_pc      = 32'h20;
        ex_imm     = 32'h40;
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_pc", pc, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        model_clear();
        exp_q.delete();
        exp_pc = 32'h0;
        #1;
        check_eq("post_rst_pc", pc, 32'h0);
        check_eq("post_rst_pred", {31'b0, pred_taken}, 32'h0);
        idle(3);
        jalr_to(32'h4c, 32'h20);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    task automatic idle_inputs();
        stall          = 1'b0;
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        next_pc_op     = 3'b000;
        ex_pc          = 32'h0;
        ex_imm         = 32'h0;
        ex_alu_result  = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
    endtask

endmodule
